// File: rtl/cpu_fetch.sv
// Fetch stage: owns the PC, issues one instruction-memory request at a time,
// and buffers responses against decode back-pressure with a 1-entry skid.
package cpu_fetch_pkg;
    localparam int VIRTUAL_ADDR_WIDTH = 32;
    typedef logic [31:0] instr_t;
endpackage

module cpu_fetch
    import cpu_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = VIRTUAL_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR   = 'h1000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   req_valid,
    output logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic                   req_ready,
    input  logic                   resp_valid,
    input  logic [INSTR_WIDTH-1:0] resp_data,
    output logic [ADDR_WIDTH-1:0]  next_PC,
    output logic                   valid_instr,
    output logic [INSTR_WIDTH-1:0] instr
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] PC_INC = ADDR_WIDTH'(4);

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  inflight_q, inflight_d;
    logic                   skid_full_q, skid_full_d;
    logic [INSTR_WIDTH-1:0] skid_instr_q, skid_instr_d;
    logic [ADDR_WIDTH-1:0]  skid_npc_q, skid_npc_d;
    logic                   valid_q, valid_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  npc_q, npc_d;

    logic                   resp_take;
    logic [ADDR_WIDTH-1:0]  resp_npc;

    assign req_valid   = rst_n && (state_q == S_FETCH) &&
                         !skid_full_q && !redirect_valid;
    assign req_addr    = pc_q;
    assign next_PC     = npc_q;
    assign valid_instr = valid_q;
    assign instr       = instr_q;

    // Only a response to our own outstanding request is ever accepted.
    assign resp_take = (state_q == S_WAIT) && resp_valid;
    assign resp_npc  = inflight_q + PC_INC;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inflight_d   = inflight_q;
        skid_full_d  = skid_full_q;
        skid_instr_d = skid_instr_q;
        skid_npc_d   = skid_npc_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        npc_d        = npc_q;

        if (redirect_valid) begin
            valid_d     = 1'b0;
            skid_full_d = 1'b0;
            pc_d        = redirect_pc;
            unique case (state_q)
                S_WAIT:  state_d = resp_valid ? S_FETCH : S_DRAIN;
                S_DRAIN: state_d = resp_valid ? S_FETCH : S_DRAIN;
                default: state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (req_valid && req_ready) begin
                        inflight_d = pc_q;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (resp_valid) begin
                        pc_d    = resp_npc;
                        state_d = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (resp_valid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_FETCH;
            endcase

            if (!stall) begin
                if (skid_full_q) begin
                    valid_d     = 1'b1;
                    instr_d     = skid_instr_q;
                    npc_d       = skid_npc_q;
                    skid_full_d = 1'b0;
                end else if (resp_take) begin
                    valid_d = 1'b1;
                    instr_d = resp_data;
                    npc_d   = resp_npc;
                end else begin
                    valid_d = 1'b0;
                end
            end else if (resp_take) begin
                if (valid_q) begin
                    skid_full_d  = 1'b1;
                    skid_instr_d = resp_data;
                    skid_npc_d   = resp_npc;
                end else begin
                    valid_d = 1'b1;
                    instr_d = resp_data;
                    npc_d   = resp_npc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= BOOT_ADDR;
            inflight_q   <= '0;
            skid_full_q  <= 1'b0;
            skid_instr_q <= '0;
            skid_npc_q   <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            npc_q        <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inflight_q   <= inflight_d;
            skid_full_q  <= skid_full_d;
            skid_instr_q <= skid_instr_d;
            skid_npc_q   <= skid_npc_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Bench for cpu_fetch: transaction-level model, per-cycle compare,
// a responding memory with programmable latency and directed scenarios.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready = 1'b1;
    logic        resp_valid = 1'b0;
    logic [31:0] resp_data = '0;
    logic [31:0] next_PC;
    logic        valid_instr;
    logic [31:0] instr;

    cpu_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .next_PC       (next_PC),
        .valid_instr   (valid_instr),
        .instr         (instr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endfunction

    // memory: answers an accepted request after mem_lat cycles
    int          mem_lat = 1;
    bit          stray = 1'b0;
    bit          pend = 1'b0;
    int          cnt = 0;
    logic [31:0] word = 32'hA0;

    always @(posedge clk) begin : mem
        logic acc;
        logic s;
        acc = req_valid && req_ready;
        s   = stray;
        #1;
        resp_valid = 1'b0;
        if (acc) begin
            pend = 1'b1;
            cnt  = mem_lat;
        end
        if (pend) begin
            if (cnt <= 1) begin
                resp_valid = 1'b1;
                resp_data  = word;
                word       = word + 32'd1;
                pend       = 1'b0;
            end else begin
                cnt--;
            end
        end
        if (s) begin
            resp_valid = 1'b1;
            resp_data  = 32'hDEAD;
        end
    end

    // model: one outstanding fetch, a delivery FIFO of output + skid
    typedef struct packed {
        logic [31:0] i;
        logic [31:0] n;
    } w_t;

    logic [31:0] m_pc = 32'h1000;
    logic [31:0] m_opc = '0;
    bit          m_out = 1'b0;
    bit          m_drop = 1'b0;
    bit          m_ov = 1'b0;
    logic [31:0] m_oi = '0;
    logic [31:0] m_on = '0;
    w_t          skq[$];
    w_t          got[$];
    bit          armed = 1'b0;

    function automatic logic exp_req();
        return rst_n && !m_out && (skq.size() == 0) && !redirect_valid;
    endfunction

    always @(posedge clk) begin : model
        logic rq;
        bit   hw;
        w_t   w;
        armed = 1'b1;
        rq = exp_req();
        hw = 1'b0;
        w  = '0;
        if (!rst_n) begin
            m_pc = 32'h1000; m_out = 0; m_drop = 0;
            m_ov = 0; m_oi = '0; m_on = '0;
            skq.delete();
        end else if (redirect_valid) begin
            m_ov = 0;
            skq.delete();
            m_pc = redirect_pc;
            if (m_out && !resp_valid) m_drop = 1;
            else begin m_out = 0; m_drop = 0; end
        end else begin
            if (m_out && resp_valid) begin
                m_out = 0;
                if (!m_drop) begin
                    hw   = 1'b1;
                    w.i  = resp_data;
                    w.n  = m_opc + 32'd4;
                    m_pc = m_opc + 32'd4;
                end
                m_drop = 0;
            end
            if (!stall) begin
                if (skq.size() != 0) begin
                    w_t h;
                    h = skq.pop_front();
                    m_ov = 1; m_oi = h.i; m_on = h.n;
                end else if (hw) begin
                    m_ov = 1; m_oi = w.i; m_on = w.n;
                end else begin
                    m_ov = 0;
                end
            end else if (hw) begin
                if (m_ov) skq.push_back(w);
                else begin m_ov = 1; m_oi = w.i; m_on = w.n; end
            end
            if (rq && req_ready) begin
                m_out = 1;
                m_opc = m_pc;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("valid_instr", {31'b0, valid_instr}, {31'b0, m_ov});
            chk("instr", instr, m_oi);
            chk("next_PC", next_PC, m_on);
            chk("req_valid", {31'b0, req_valid}, {31'b0, exp_req()});
            if (exp_req()) chk("req_addr", req_addr, m_pc);
            if (rst_n && valid_instr && !stall) got.push_back({instr, next_PC});
        end
    end

    int cyc = 0;

    task automatic goto(int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        #2;
        chk("rst_valid", {31'b0, valid_instr}, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_npc", next_PC, 32'd0);
        chk("boot_req", {31'b0, req_valid}, 32'd1);
        chk("boot_addr", req_addr, 32'h1000);

        goto(6);
        chk("got_cnt", got.size(), 32'd2);
        if (got.size() >= 2) begin
            chk("got0_i", got[0].i, 32'hA0);
            chk("got0_n", got[0].n, 32'h1004);
            chk("got1_i", got[1].i, 32'hA1);
            chk("got1_n", got[1].n, 32'h1008);
        end
        stall = 1'b1;

        goto(9);
        #2;
        chk("stall_noreq", {31'b0, req_valid}, 32'd0);
        chk("stall_hold", instr, 32'hA2);

        goto(12);
        stall = 1'b0;
        goto(13);
        #2;
        chk("skid_valid", {31'b0, valid_instr}, 32'd1);
        chk("skid_instr", instr, 32'hA3);
        chk("skid_npc", next_PC, 32'h1010);
        chk("resume_addr", req_addr, 32'h1010);
        mem_lat = 3;

        goto(14);
        redirect_valid = 1'b1;
        redirect_pc = 32'h2000;
        goto(15);
        redirect_valid = 1'b0;
        mem_lat = 1;
        goto(17);
        #2;
        chk("drain_valid", {31'b0, valid_instr}, 32'd0);
        chk("drain_req", {31'b0, req_valid}, 32'd1);
        chk("drain_addr", req_addr, 32'h2000);

        goto(19);
        stall = 1'b1;
        goto(20);
        stray = 1'b1;
        goto(21);
        stray = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        #2;
        chk("pre_flush", instr, 32'hA5);
        goto(22);
        redirect_valid = 1'b0;
        stall = 1'b0;
        #2;
        chk("flush_valid", {31'b0, valid_instr}, 32'd0);
        chk("flush_addr", req_addr, 32'h3000);

        goto(24);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #2;
        chk("a7_instr", instr, 32'hA7);
        chk("a7_npc", next_PC, 32'h3004);
        goto(25);
        redirect_valid = 1'b0;
        goto(27);
        #2;
        chk("wrap_instr", instr, 32'hA8);
        chk("wrap_npc", next_PC, 32'h0);
        chk("wrap_addr", req_addr, 32'h0);
        mem_lat = 3;

        goto(28);
        rst_n = 1'b0;
        req_ready = 1'b0;
        #2;
        chk("rst_noreq", {31'b0, req_valid}, 32'd0);
        goto(29);
        rst_n = 1'b1;
        #2;
        chk("rr_valid", {31'b0, valid_instr}, 32'd0);
        chk("rr_npc", next_PC, 32'd0);
        chk("rr_addr", req_addr, 32'h1000);
        goto(31);
        chk("stray_ign", {31'b0, valid_instr}, 32'd0);
        req_ready = 1'b1;
        mem_lat = 1;
        goto(33);
        #2;
        chk("rr_instr", instr, 32'hAA);
        chk("rr_npc2", next_PC, 32'h1004);

        goto(37);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
